// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses framed UART commands (A5 CMD LEN payload CHK)
// and issues register writes or baud reconfiguration.
// Ports: clk, rst_n (async low); rx_byte/rx_done from the byte receiver;
// baud_set to the receiver; reg_wr_en/reg_addr/reg_wdata register bus;
// frame_ok/frame_err pulses, err_code (0 chk,1 len,2 cmd,3 timeout).
// Option: UART_CMD_TIMEOUT_EN builds the inter-byte timeout counter.
module uart_cmd_ctrl #(
  parameter int MAX_LEN     = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_done,
  output logic [2:0] baud_set,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_EXEC
  } state_t;

  state_t     state_q, state_n;
  logic [7:0] cmd_q, xor_q;
  logic [3:0] len_q, idx_q;
  logic [7:0] buf_q [16];

  logic       err_p, wr_p, baud_p;
  logic [1:0] code_p;
  logic       len_bad;
  logic       tmo;

  assign len_bad = rx_byte > 8'(MAX_LEN);

`ifdef UART_CMD_TIMEOUT_EN
  logic [19:0] cnt_q;
  logic [19:0] cnt_inc;
  logic        counting;

  assign counting = state_q inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK};
  assign cnt_inc  = cnt_q + 20'd1;
  // Fires on the cycle the counter would step onto TIMEOUT_CYC-1.
  // A byte in the same cycle wins.
  assign tmo = counting && !rx_done &&
               (cnt_inc == 20'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (rx_done || tmo || !counting) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_inc;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    err_p   = 1'b0;
    code_p  = 2'd0;
    wr_p    = 1'b0;
    baud_p  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_done && rx_byte == 8'hA5) state_n = S_CMD;
      end
      S_CMD: begin
        if (rx_done) state_n = S_LEN;
      end
      S_LEN: begin
        if (rx_done) begin
          if (len_bad) begin
            err_p   = 1'b1;
            code_p  = 2'd1;
            state_n = S_IDLE;
          end else if (rx_byte == 8'd0) begin
            state_n = S_CHK;
          end else begin
            state_n = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_done && idx_q == 4'(len_q - 4'd1)) state_n = S_CHK;
      end
      S_CHK: begin
        if (rx_done) begin
          if (rx_byte != xor_q) begin
            err_p   = 1'b1;
            code_p  = 2'd0;
            state_n = S_IDLE;
          end else begin
            state_n = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        state_n = S_IDLE;
        unique case (1'b1)
          (cmd_q == 8'h01 && len_q == 4'd2): wr_p = 1'b1;
          (cmd_q == 8'h02 && len_q == 4'd1 &&
           buf_q[0] <= 8'd5): baud_p = 1'b1;
          default: begin
            err_p  = 1'b1;
            code_p = 2'd2;
          end
        endcase
      end
      default: state_n = S_IDLE;
    endcase
    if (tmo) begin
      err_p   = 1'b1;
      code_p  = 2'd3;
      state_n = S_IDLE;
    end
  end

  // Frame datapath: command, length, payload buffer, running XOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      xor_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else if (rx_done) begin
      unique case (state_q)
        S_CMD: begin
          cmd_q <= rx_byte;
          xor_q <= rx_byte;
        end
        S_LEN: begin
          // LEN is kept even when zero so EXEC never sees a stale length.
          if (!len_bad) len_q <= rx_byte[3:0];
          xor_q <= xor_q ^ rx_byte;
          idx_q <= '0;
        end
        S_PAYLOAD: begin
          buf_q[idx_q] <= rx_byte;
          xor_q        <= xor_q ^ rx_byte;
          idx_q        <= idx_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_set  <= 3'd1;
      reg_wr_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
    end else begin
      reg_wr_en <= wr_p;
      frame_ok  <= wr_p | baud_p;
      frame_err <= err_p;
      if (err_p) err_code <= code_p;
      if (wr_p) begin
        reg_addr  <= buf_q[0];
        reg_wdata <= buf_q[1];
      end
      if (baud_p) baud_set <= buf_q[0][2:0];
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: self-checking bench for uart_cmd_ctrl.
// Frame-level reference model plus directed latency checks.
module tb_uart_cmd_ctrl;
  localparam int MAXL = 4;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_done = 1'b0;
  logic [2:0] baud_set;
  logic       reg_wr_en;
  logic [7:0] reg_addr, reg_wdata;
  logic       frame_ok, frame_err;
  logic [1:0] err_code;

  uart_cmd_ctrl #(.MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_done(rx_done),
    .baud_set(baud_set), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_ok = 0, n_err = 0;

  // Model of the held outputs.
  logic [2:0] e_baud = 3'd1;
  logic [7:0] e_addr = '0, e_wdata = '0;
  logic [1:0] e_code = '0;
  logic [7:0] pay [0:14];

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_wr_en) n_wr++;
      if (frame_ok) n_ok++;
      if (frame_err) n_err++;
      checks++;
      if ((reg_wr_en && !frame_ok) || (frame_ok && frame_err)) begin
        errors++;
        $display("FAIL strobe_coherence wr=%b ok=%b err=%b",
                 reg_wr_en, frame_ok, frame_err);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_byte = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic noise(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      send_byte(b, $urandom_range(0, 2));
    end
  endtask

  // Sends one frame and checks its outcome against the frame rules.
  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] len,
                          input bit bad_chk, input string tag);
    int w0, o0, e0, xw, xo, xe;
    logic [7:0] x;
    w0 = n_wr; o0 = n_ok; e0 = n_err;
    xw = 0; xo = 0; xe = 0;
    x = cmd ^ len;
    send_byte(8'hA5, $urandom_range(0, 3));
    send_byte(cmd, $urandom_range(0, 3));
    send_byte(len, $urandom_range(0, 3));
    if (len > MAXL) begin
      xe = 1; e_code = 2'd1;
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        x = x ^ pay[i];
        send_byte(pay[i], $urandom_range(0, 3));
      end
      if (bad_chk) x = x ^ 8'($urandom_range(1, 255));
      send_byte(x, 0);
      if (bad_chk) begin
        xe = 1; e_code = 2'd0;
      end else if (cmd == 8'h01 && len == 8'd2) begin
        xw = 1; xo = 1; e_addr = pay[0]; e_wdata = pay[1];
      end else if (cmd == 8'h02 && len == 8'd1 && pay[0] <= 8'd5) begin
        xo = 1; e_baud = pay[0][2:0];
      end else begin
        xe = 1; e_code = 2'd2;
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({n_wr - w0, n_ok - o0, n_err - e0} !== {xw, xo, xe}) begin
      errors++;
      $display("FAIL %s pulses wr/ok/err=%0d/%0d/%0d exp %0d/%0d/%0d",
               tag, n_wr - w0, n_ok - o0, n_err - e0, xw, xo, xe);
    end
    checks++;
    if ({baud_set, reg_addr, reg_wdata, err_code} !==
        {e_baud, e_addr, e_wdata, e_code}) begin
      errors++;
      $display("FAIL %s held baud=%0d addr=%h wd=%h code=%0d exp %0d %h %h %0d",
               tag, baud_set, reg_addr, reg_wdata, err_code,
               e_baud, e_addr, e_wdata, e_code);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({baud_set, reg_wr_en, reg_addr, reg_wdata, frame_ok, frame_err,
         err_code} !== {3'd1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_values baud=%0d wr=%b a=%h d=%h ok=%b err=%b c=%0d",
               baud_set, reg_wr_en, reg_addr, reg_wdata, frame_ok,
               frame_err, err_code);
    end
  endtask

  task automatic test_write;
    send_byte(8'hA5, 1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 2);
    send_byte(8'h10, 0);
    send_byte(8'h3C, 1);
    send_byte(8'h2F, 0);
    checks++;
    if ({reg_wr_en, frame_ok} !== 2'b00) begin
      errors++;
      $display("FAIL write_early wr=%b ok=%b exp 0 0", reg_wr_en, frame_ok);
    end
    @(negedge clk);
    checks++;
    if ({reg_wr_en, frame_ok, reg_addr, reg_wdata} !==
        {1'b1, 1'b1, 8'h10, 8'h3C}) begin
      errors++;
      $display("FAIL write_strobe wr=%b ok=%b a=%h d=%h exp 1 1 10 3c",
               reg_wr_en, frame_ok, reg_addr, reg_wdata);
    end
    @(negedge clk);
    checks++;
    if ({reg_wr_en, frame_ok} !== 2'b00) begin
      errors++;
      $display("FAIL write_width wr=%b ok=%b exp 0 0", reg_wr_en, frame_ok);
    end
    e_addr = 8'h10; e_wdata = 8'h3C;
  endtask

  task automatic test_baud;
    pay[0] = 8'h04;
    do_frame(8'h02, 8'd1, 1'b0, "baud_set4");
    pay[0] = 8'h07;
    do_frame(8'h02, 8'd1, 1'b0, "baud_bad_value");
  endtask

  task automatic test_bad_chk;
    pay[0] = 8'h10; pay[1] = 8'h3C;
    do_frame(8'h01, 8'd2, 1'b1, "bad_chk");
    pay[0] = 8'h55; pay[1] = 8'hA5;
    do_frame(8'h01, 8'd2, 1'b0, "after_bad_chk");
  endtask

  task automatic test_len_err;
    int e0;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h05, 0);
    checks++;
    if ({frame_err, err_code} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL len_err err=%b code=%0d exp 1 1", frame_err, err_code);
    end
    e_code = 2'd1;
    @(negedge clk);
    e0 = n_err;
    send_byte(8'h11, 1);
    send_byte(8'h22, 4);
    checks++;
    if (n_err != e0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL len_err_idle extra_err=%0d exp 0", n_err - e0);
    end
  endtask

  task automatic test_timeout;
    int k;
    bit seen;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
`ifdef UART_CMD_TIMEOUT_EN
    k = 0;
    seen = 1'b0;
    while (!seen && k < TMO + 20) begin
      if (frame_err) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    checks++;
    if (!seen || k != TMO - 1 || err_code !== 2'd3) begin
      errors++;
      $display("FAIL timeout seen=%b at=%0d code=%0d exp 1 %0d 3",
               seen, k, err_code, TMO - 1);
    end
    e_code = 2'd3;
    pay[0] = 8'h10; pay[1] = 8'h3C;
    do_frame(8'h01, 8'd2, 1'b0, "after_timeout");
`else
    k = n_err;
    seen = 1'b0;
    repeat (3 * TMO) @(negedge clk);
    checks++;
    if (n_err != k) begin
      errors++;
      $display("FAIL no_timeout errs=%0d exp 0", n_err - k);
    end
    send_byte(8'h02, 1);
    send_byte(8'h21, 1);
    send_byte(8'h43, 1);
    send_byte(8'h01 ^ 8'h02 ^ 8'h21 ^ 8'h43, 4);
    e_addr = 8'h21; e_wdata = 8'h43;
    checks++;
    if ({reg_addr, reg_wdata} !== {e_addr, e_wdata}) begin
      errors++;
      $display("FAIL resume_after_wait a=%h d=%h exp %h %h",
               reg_addr, reg_wdata, e_addr, e_wdata);
    end
`endif
  endtask

  task automatic test_reset_midframe;
    int w0, o0;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    e_baud = 3'd1; e_addr = '0; e_wdata = '0; e_code = '0;
    w0 = n_wr; o0 = n_ok;
    send_byte(8'h02, 1);
    send_byte(8'h10, 1);
    send_byte(8'h3C, 1);
    send_byte(8'h2F, 4);
    checks++;
    if (n_wr != w0 || n_ok != o0 || reg_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_midframe wr=%0d ok=%0d a=%h exp 0 0 00",
               n_wr - w0, n_ok - o0, reg_addr);
    end
  endtask

  task automatic test_random;
    int kind;
    logic [7:0] cmd, len;
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < 15; i++) pay[i] = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 7);
      cmd = 8'h01; len = 8'd2;
      if (kind == 3 || kind == 4) begin
        cmd = 8'h02; len = 8'd1; pay[0] = 8'($urandom_range(0, 7));
      end else if (kind == 5) begin
        cmd = 8'($urandom_range(0, 3));
        len = 8'($urandom_range(0, MAXL));
      end else if (kind == 7) begin
        len = 8'($urandom_range(MAXL + 1, 255));
      end
      do_frame(cmd, len, kind == 6, "random_frame");
      noise($urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 8; f++) begin
      pay[0] = 8'(f * 17); pay[1] = 8'(~f);
      do_frame(8'h01, 8'd2, 1'b0, "b2b_write");
      pay[0] = 8'(f % 6);
      do_frame(8'h02, 8'd1, 1'b0, "b2b_baud");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_write();
    test_baud();
    test_reset_midframe();
    test_bad_chk();
    test_len_err();
    test_timeout();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command-frame controller for the UART receive path. It consumes the byte stream from the UART byte receiver (`data_byte`/`rx_done`) and parses framed commands. It validates length and checksum, then either issues single-cycle register writes to the system register bus or reconfigures the receiver's `baud_set` select. It sits between the UART byte receiver and the FPGA register file, and drives the receiver's baud selection.

## Interface
- `MAX_LEN`, 4: maximum payload bytes per frame (1..15).
- `TIMEOUT_CYC`, 1000000: inter-byte timeout in clk cycles (20 ms at 50 MHz); width 20 bits.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx_byte`  in  8  byte from the UART byte receiver, valid in the `rx_done` cycle.
- `rx_done`  in  1  one-cycle strobe, byte received.
- `baud_set`  out  3  baud select to the receiver; reset 3'd1 (9600 bps).
- `reg_wr_en`  out  1  one-cycle register write strobe; reset 0.
- `reg_addr`  out  8  write address, held until the next write; reset 0.
- `reg_wdata`  out  8  write data, held until the next write; reset 0.
- `frame_ok`  out  1  one-cycle pulse, frame accepted and executed; reset 0.
- `frame_err`  out  1  one-cycle pulse, frame rejected; reset 0.
- `err_code`  out  2  reason for the last error, held; reset 0. Codes: 0 checksum, 1 length, 2 command/value, 3 timeout.

## Operation
- Frame format: SYNC 0xA5, CMD, LEN, LEN payload bytes, CHK.
- CHK is the XOR of CMD, LEN and all payload bytes.
- FSM states: IDLE, CMD, LEN, PAYLOAD, CHK, EXEC. All transitions except EXEC→IDLE occur only in `rx_done` cycles.
- IDLE: 0xA5 → CMD. Any other byte is ignored, with no error.
- CMD: store the byte, initialise the running XOR to it → LEN.
- LEN: if LEN > MAX_LEN, pulse `frame_err` with code 1 and go to IDLE. If LEN = 0, go to CHK. Otherwise store LEN and go to PAYLOAD.
- PAYLOAD: write each byte to buffer[idx] and XOR it in. idx counts 0..LEN-1; after the last byte → CHK.
- CHK: if the byte differs from the running XOR, pulse `frame_err` with code 0 and go to IDLE. If it matches → EXEC.
- EXEC lasts one cycle, then returns to IDLE:
  - CMD 0x01 (WRITE): requires LEN = 2. Sets `reg_addr` = buffer[0] and `reg_wdata` = buffer[1], and pulses `reg_wr_en` and `frame_ok`.
  - CMD 0x02 (BAUD): requires LEN = 1 and buffer[0] ≤ 5. Loads `baud_set` = buffer[0][2:0] and pulses `frame_ok`.
  - Any other CMD, a wrong LEN for a known CMD, or a BAUD value > 5: pulse `frame_err` with code 2. No state change.
- A frame_err leaves `baud_set`, `reg_addr` and `reg_wdata` untouched.
- A 0xA5 received outside IDLE is treated as data. There is no resynchronisation except via error or timeout.

## Timing
- All outputs are registered.
- `reg_wr_en`, `frame_ok` and `frame_err` are exactly one cycle wide. `reg_wr_en` and `frame_ok` always coincide.
- Latency, CHK byte `rx_done` in cycle N:
  - FSM enters EXEC in cycle N+1.
  - Strobes and `baud_set` update are visible in cycle N+2.
- Latency for errors detected in the LEN or CHK state: `frame_err` is visible in cycle N+1.
- `rx_done` during EXEC is dropped. This cannot occur at supported baud rates.
- The new `baud_set` takes effect from the next byte. Frames sent by the host after the response must use the new rate.
- Reset mid-frame: the FSM goes to IDLE, the buffer and XOR are cleared, and all outputs return to their reset values, including `baud_set` = 1.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - A 20-bit counter clears on every `rx_done` and increments in the CMD, LEN, PAYLOAD and CHK states.
  - When it reaches TIMEOUT_CYC-1 with no `rx_done`, the block pulses `frame_err` with code 3, returns to IDLE and clears the counter.
  - If `rx_done` arrives in the same cycle as the timeout, the byte wins and no timeout is raised.
- Undefined: no counter is built. A partial frame waits indefinitely, and code 3 is never produced.

## Test plan
- Bytes A5 01 02 10 3C 2F → `reg_wr_en` for 1 cycle with `reg_addr` = 0x10 and `reg_wdata` = 0x3C, plus `frame_ok`, 2 cycles after the last `rx_done`.
- Bytes A5 02 01 04 07 → `baud_set` changes 1→4 and `frame_ok` pulses. Then A5 02 01 07 04 → `frame_err` with code 2, and `baud_set` stays 4.
- Bytes A5 01 02 10 3C 2E (bad CHK) → `frame_err` with code 0 and no `reg_wr_en`. A following valid frame is accepted.
- Bytes A5 01 05 → `frame_err` with code 1 the cycle after the LEN byte. Subsequent bytes 11 22 are ignored in IDLE.
- With `UART_CMD_TIMEOUT_EN`, bytes A5 01 then silence → `frame_err` with code 3 TIMEOUT_CYC cycles after the 0x01 `rx_done`. Then A5 01 02 10 3C 2F executes normally.
- Assert `rst_n` after A5 01 02 → all outputs return to reset values. Then 02 10 3C 2F produces no strobe, because the bytes are ignored in IDLE.
